// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// mips_mem_arbiter : shares one fixed-latency 1024x32 memory between MIPS IF/DM.
// Optional stats counters under MIPS_MEM_ARB_STATS_EN.        Revision: 1.0
// ============================================================================
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MIPS_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       if_acc_cnt,
  output logic [31:0]       dm_acc_cnt,
  output logic [15:0]       starve_evt_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LIM    = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        owner_dm;
  logic        flushed;
  logic        if_rvalid_q;
  logic        idle;
  logic        starved;
  logic        squash;

  // Grants are gated by rst_n so nothing is offered while reset is asserted.
  assign idle    = rst_n && (state == S_IDLE);
  assign starved = (starve_cnt == STARVE_LIM);
  assign if_gnt  = idle && if_req && (!dm_req || starved);
  assign dm_gnt  = idle && dm_req && !(if_req && starved);

  // A flush arriving in the completion cycle itself still kills the fetch.
  assign squash    = flushed || if_flush;
  assign if_rvalid = if_rvalid_q && !if_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_cnt     <= 3'd0;
      starve_cnt  <= 4'd0;
      owner_dm    <= 1'b0;
      flushed     <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata    <= '0;
      dm_rvalid   <= 1'b0;
      dm_rdata    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid   <= 1'b0;
      mem_en      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_gnt) begin
            owner_dm   <= 1'b0;
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            starve_cnt <= 4'd0;
            flushed    <= 1'b0;
            mem_en     <= 1'b1;
            state      <= S_ISSUE;
          end else if (dm_gnt) begin
            owner_dm   <= 1'b1;
            mem_addr   <= dm_addr;
            mem_we     <= dm_we;
            mem_wdata  <= dm_wdata;
            flushed    <= 1'b0;
            mem_en     <= 1'b1;
            state      <= S_ISSUE;
            if (if_req && (starve_cnt < STARVE_LIM))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          lat_cnt <= 3'd1;
          state   <= S_WAIT;
          if (if_flush && !owner_dm)
            flushed <= 1'b1;
        end
        S_WAIT: begin
          if (if_flush && !owner_dm)
            flushed <= 1'b1;
          if (lat_cnt == LAT_LIM) begin
            lat_cnt <= 3'd0;
            state   <= S_RESP;
            if (owner_dm) begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= mem_we ? '0 : mem_rdata;
            end else if (!squash) begin
              if_rvalid_q <= 1'b1;
              if_rdata    <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_RESP: begin
          flushed <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MIPS_MEM_ARB_STATS_EN
  // A forced grant is one where IF wins only because it was starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_acc_cnt     <= 32'd0;
      dm_acc_cnt     <= 32'd0;
      starve_evt_cnt <= 16'd0;
    end else begin
      if (if_gnt)
        if_acc_cnt <= if_acc_cnt + 32'd1;
      if (dm_gnt)
        dm_acc_cnt <= dm_acc_cnt + 32'd1;
      if (if_gnt && dm_req)
        starve_evt_cnt <= starve_evt_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Single-clock arbiter that shares one single-ported 1024x32 unified memory between the MIPS32 pipeline's instruction-fetch (IF) port and data (MEM-stage LW/SW) port.
- Grants one outstanding access at a time and sequences it through a fixed-latency memory.
- Prevents IF starvation with an aging counter.
- Supports squashing an in-flight fetch on a taken branch.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid (legal 1..7).
- STARVE_MAX, 3, consecutive IF losses before IF is forced to win (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_flush  in  1  taken branch; squash the outstanding fetch.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data access accepted this cycle.
- dm_rvalid  out  1  one-cycle completion pulse (load data or store ack).
- dm_rdata  out  DATA_W  load data; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; latency counter 0; starve counter 0; owner cleared; flush flag 0.
- States:
  - IDLE: accept a request.
  - ISSUE: mem_en high for exactly one cycle.
  - WAIT: count MEM_LAT cycles.
  - RESP: rvalid pulse.
- Transitions:
  - IDLE->ISSUE when any request is granted.
  - ISSUE->WAIT.
  - WAIT->RESP when the counter reaches MEM_LAT.
  - RESP->IDLE.
- Grant:
  - if_gnt and dm_gnt are combinational, asserted only in IDLE, and never both in the same cycle.
  - Priority: dm wins. IF wins instead when starve_cnt == STARVE_MAX.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each dm grant while if_req = 1.
  - Clears on an if grant.
- On a grant edge, the arbiter registers mem_addr/mem_we/mem_wdata and the owner. mem_we = 0 for IF.
- Timing: grant in cycle T -> mem_en in T+1 -> mem_rdata sampled in T+1+MEM_LAT -> owner rvalid and rdata registered in T+2+MEM_LAT.
  - Next grant is possible in the RESP cycle's following IDLE cycle.
  - Back-to-back throughput is one access per MEM_LAT+3 cycles.
- rdata holds its value until the next rvalid for that port.
- A request deasserted before its grant is dropped silently.
- if_flush:
  - While an IF access is in ISSUE/WAIT/RESP, the access completes on the bus but if_rvalid is suppressed.
  - if_flush in IDLE with if_req = 1 has no effect on that grant decision.
  - if_flush never affects dm accesses.
- Stores: dm_rvalid pulses with dm_rdata = 0.
- Asynchronous reset mid-access: mem_en and all rvalid outputs drop immediately, and no completion is delivered. The requester re-requests after reset.

Optional Feature:
- Macro: MIPS_MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs if_acc_cnt[31:0], dm_acc_cnt[31:0] and starve_evt_cnt[15:0].
  - if_acc_cnt and dm_acc_cnt count grants per port; starve_evt_cnt counts forced-IF grants.
  - All are wrapping counters, cleared by rst_n.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single fetch, MEM_LAT = 1: if_req = 1, if_addr = 5, mem returns 32'h280a00c8 -> if_gnt in T0, mem_en/mem_addr = 5 in T1, if_rvalid with if_rdata = 32'h280a00c8 in T3.
- Store then load: dm_we = 1, addr 198, wdata 24; then a load of 198 -> mem_we = 1 with mem_wdata = 24, dm_rvalid with dm_rdata = 0; then dm_rvalid with dm_rdata = 24 (memory model echoes the write).
- Contention: if_req and dm_req held high continuously, STARVE_MAX = 3 -> grant order dm, dm, dm, if, dm, dm, dm, if; no cycle with both grants.
- Flush: IF grant at T0, if_flush pulse at T2 -> mem_en still pulses at T1, if_rvalid stays 0 at T3; a subsequent fetch completes normally.
- Reset mid-access: assert rst_n = 0 during WAIT with MEM_LAT = 4 -> all outputs 0 immediately, no rvalid after release, next request is granted from IDLE.
- MIPS_MEM_ARB_STATS_EN: 3 if + 5 dm accesses with 1 forced grant -> if_acc_cnt = 3, dm_acc_cnt = 5, starve_evt_cnt = 1.
